// File: rtl/dcache_core_pkg.sv
// rtl/dcache_core_pkg.sv - shared widths, state encodings and byte-merge helper for dcache_core
package dcache_core_pkg;

    localparam int INDEX_W  = 8;
    localparam int TAG_W    = 20;
    localparam int OFFSET_W = 4;
    localparam int SETS     = 1 << INDEX_W;
    localparam int LINE_W   = 128;

    localparam logic [2:0] DC_LINE_TYPE = 3'b100;

    typedef enum logic [2:0] {
        DC_IDLE    = 3'd0,
        DC_LOOKUP  = 3'd1,
        DC_MISS    = 3'd2,
        DC_REPLACE = 3'd3,
        DC_REFILL  = 3'd4,
        DC_RESPOND = 3'd5
    } dc_state_e;

    // Byte-lane merge: lanes with strb set take new_w, others keep old_w.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// rtl/dcache_line_ram.sv - 256-set line store: valid/dirty/tag/128-bit data per set
// Purpose: register-array storage for the direct-mapped cache.
// Ports:
//   clk, reset                 clock, synchronous active-high reset (clears V and D only)
//   rd_index -> rd_v/rd_d/rd_tag/rd_line   asynchronous read of one set
//   wr_index                   set written by every write port below
//   data_we/data_word/data_strb/data_wdata  one 32-bit word, byte-enabled
//   tag_we/tag_wdata, v_we/v_wdata, d_we/d_wdata  metadata writes
module dcache_line_ram
    import dcache_core_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_v,
    output logic               rd_d,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               data_we,
    input  logic [1:0]         data_word,
    input  logic [3:0]         data_strb,
    input  logic [31:0]        data_wdata,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   tag_wdata,
    input  logic               v_we,
    input  logic               v_wdata,
    input  logic               d_we,
    input  logic               d_wdata
);

    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    assign rd_v    = valid_q[rd_index];
    assign rd_d    = dirty_q[rd_index];
    assign rd_tag  = tag_q[rd_index];
    assign rd_line = data_q[rd_index];

    // Data and tag contents are meaningless until V is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_strb[b]) begin
                    data_q[wr_index][{data_word, b[1:0], 3'b000} +: 8] <= data_wdata[b*8 +: 8];
                end
            end
        end
        if (tag_we) begin
            tag_q[wr_index] <= tag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (v_we) begin
                valid_q[wr_index] <= v_wdata;
            end
            if (d_we) begin
                dirty_q[wr_index] <= d_wdata;
            end
        end
    end

endmodule

// File: rtl/dcache_core.sv
// rtl/dcache_core.sv - direct-mapped write-back write-allocate data cache controller
// Purpose: accepts one CPU load/store at a time, answers hits in the lookup cycle,
// and services misses via a line writeback (dirty victim) then a line refill.
// Ports:
//   clk, reset                            clock, synchronous active-high reset
//   valid/op/index/tag/offset/wstrb/wdata CPU request, accepted when valid && addr_ok
//   addr_ok, data_ok, rdata               CPU handshake and load data
//   rd_req/rd_type/rd_addr/rd_rdy         refill request to the bridge
//   ret_valid/ret_last/ret_data           refill beats, word 0..3
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy  victim writeback to the bridge
module dcache_core
    import dcache_core_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                op,
    input  logic [INDEX_W-1:0]  index,
    input  logic [TAG_W-1:0]    tag,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [3:0]          wstrb,
    input  logic [31:0]         wdata,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [31:0]         rdata,
    output logic                rd_req,
    output logic [2:0]          rd_type,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data,
    output logic                wr_req,
    output logic [2:0]          wr_type,
    output logic [31:0]         wr_addr,
    output logic [3:0]          wr_wstrb,
    output logic [LINE_W-1:0]   wr_data,
    input  logic                wr_rdy
);

    dc_state_e state, state_n;

    logic               req_op;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic [3:0]         req_wstrb;
    logic [31:0]        req_wdata;
    logic [1:0]         cnt;
    logic [31:0]        rdata_r;

    logic               ram_v, ram_d;
    logic [TAG_W-1:0]   ram_tag;
    logic [LINE_W-1:0]  ram_line;
    logic               hit;
    logic [31:0]        beat_word;

    logic               ram_data_we;
    logic [1:0]         ram_data_word;
    logic [3:0]         ram_data_strb;
    logic [31:0]        ram_data_wdata;
    logic               ram_tag_we;
    logic               ram_v_we, ram_v_wdata;
    logic               ram_d_we, ram_d_wdata;

    // Byte offset within a word is irrelevant to a word-granular cache.
    logic unused_offset_lo;
    assign unused_offset_lo = ^offset[1:0];

    dcache_line_ram u_ram (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (req_index),
        .rd_v       (ram_v),
        .rd_d       (ram_d),
        .rd_tag     (ram_tag),
        .rd_line    (ram_line),
        .wr_index   (req_index),
        .data_we    (ram_data_we),
        .data_word  (ram_data_word),
        .data_strb  (ram_data_strb),
        .data_wdata (ram_data_wdata),
        .tag_we     (ram_tag_we),
        .tag_wdata  (req_tag),
        .v_we       (ram_v_we),
        .v_wdata    (ram_v_wdata),
        .d_we       (ram_d_we),
        .d_wdata    (ram_d_wdata)
    );

    assign hit = ram_v && (ram_tag == req_tag);

    // A store miss folds its write into the matching refill beat, so the line
    // lands in the array already updated and no second write pass is needed.
    assign beat_word = (req_op && (cnt == req_word))
                     ? merge_word(ret_data, req_wdata, req_wstrb)
                     : ret_data;

    assign addr_ok  = (state == DC_IDLE);
    assign rd_type  = DC_LINE_TYPE;
    assign rd_addr  = {req_tag, req_index, 4'b0000};
    assign wr_type  = DC_LINE_TYPE;
    assign wr_wstrb = 4'hf;
    // Victim fields come straight from the array; nothing writes the set while
    // in MISS, so they stay stable until wr_rdy.
    assign wr_addr  = {ram_tag, req_index, 4'b0000};
    assign wr_data  = ram_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DC_IDLE;
            cnt       <= 2'd0;
            rdata_r   <= 32'd0;
            req_op    <= 1'b0;
            req_index <= '0;
            req_tag   <= '0;
            req_word  <= 2'd0;
            req_wstrb <= 4'd0;
            req_wdata <= 32'd0;
        end else begin
            state <= state_n;
            if (state == DC_IDLE && valid) begin
                req_op    <= op;
                req_index <= index;
                req_tag   <= tag;
                req_word  <= offset[3:2];
                req_wstrb <= wstrb;
                req_wdata <= wdata;
            end
            if (state == DC_REPLACE && rd_rdy) begin
                cnt <= 2'd0;
            end
            if (state == DC_REFILL && ret_valid) begin
                cnt <= cnt + 2'd1;
                if (cnt == req_word) begin
                    rdata_r <= beat_word;
                end
            end
        end
    end

    always_comb begin
        state_n        = state;
        data_ok        = 1'b0;
        rdata          = 32'd0;
        rd_req         = 1'b0;
        wr_req         = 1'b0;
        ram_data_we    = 1'b0;
        ram_data_word  = req_word;
        ram_data_strb  = req_wstrb;
        ram_data_wdata = req_wdata;
        ram_tag_we     = 1'b0;
        ram_v_we       = 1'b0;
        ram_v_wdata    = 1'b0;
        ram_d_we       = 1'b0;
        ram_d_wdata    = 1'b0;
        case (state)
            DC_IDLE: begin
                if (valid) begin
                    state_n = DC_LOOKUP;
                end
            end
            DC_LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = ram_line[{req_word, 5'b00000} +: 32];
                    if (req_op) begin
                        ram_data_we = 1'b1;
                        if (|req_wstrb) begin
                            ram_d_we    = 1'b1;
                            ram_d_wdata = 1'b1;
                        end
                    end
                    state_n = DC_IDLE;
                end else begin
                    state_n = DC_MISS;
                end
            end
            DC_MISS: begin
                if (ram_v && ram_d) begin
                    wr_req = 1'b1;
                    if (wr_rdy) begin
                        state_n = DC_REPLACE;
                    end
                end else begin
                    state_n = DC_REPLACE;
                end
            end
            DC_REPLACE: begin
                rd_req = 1'b1;
                if (rd_rdy) begin
                    state_n = DC_REFILL;
                end
            end
            DC_REFILL: begin
                if (ret_valid) begin
                    ram_data_we    = 1'b1;
                    ram_data_word  = cnt;
                    ram_data_strb  = 4'hf;
                    ram_data_wdata = beat_word;
                    // ret_last closes the refill even if fewer than 4 beats arrived.
                    if (ret_last) begin
                        ram_tag_we  = 1'b1;
                        ram_v_we    = 1'b1;
                        ram_v_wdata = 1'b1;
                        ram_d_we    = 1'b1;
                        ram_d_wdata = req_op && (|req_wstrb);
                        state_n     = DC_RESPOND;
                    end
                end
            end
            DC_RESPOND: begin
                data_ok = 1'b1;
                rdata   = rdata_r;
                state_n = DC_IDLE;
            end
            default: begin
                state_n = DC_IDLE;
            end
        endcase
    end

endmodule
